// File: rtl/obi_mem_responder.sv
// -----------------------------------------------------------------------------
// obi_mem_responder
//
// OBI responder backed by a word-addressed 32-bit SRAM. Serves one master port
// with a fixed response latency, a bounded number of in-flight transactions
// and an external stall input that forces the grant low.
//
// Ports:
//   clk_i       in   clock, all state updates on the rising edge
//   rst_ni      in   asynchronous active-low reset (SRAM contents not reset)
//   obi_req_i   in   obi_req_t  {req, addr[31:0], we, be[3:0], wdata[31:0]}
//   obi_resp_o  out  obi_resp_t {gnt, rvalid, rdata[31:0]}
//   stall_i     in   holds gnt low while high
//   err_o       out  high together with rvalid for an out-of-range access
//
// The package obi_pkg defining the bus structs lives in this file so the
// responder is self-contained.
// -----------------------------------------------------------------------------

package obi_pkg;

   typedef struct packed {
      logic        req;
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_req_t;

   typedef struct packed {
      logic        gnt;
      logic        rvalid;
      logic [31:0] rdata;
   } obi_resp_t;

endpackage

module obi_mem_responder
   import obi_pkg::*;
#(
   parameter int unsigned MEM_WORDS       = 1024,
   parameter int unsigned LATENCY         = 1,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] ERR_DATA        = 32'hDEAD_BEEF
) (
   input  logic      clk_i,
   input  logic      rst_ni,
   input  obi_req_t  obi_req_i,
   output obi_resp_t obi_resp_o,
   input  logic      stall_i,
   output logic      err_o
);

   localparam int unsigned         IDX_W       = $clog2(MEM_WORDS);
   localparam int unsigned         CNT_W       = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [IDX_W:0]      MEM_WORDS_L = (IDX_W + 1)'(MEM_WORDS);
   localparam logic [CNT_W-1:0]    MAX_OUT_L   = CNT_W'(MAX_OUTSTANDING);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [31:0]        mem_q [MEM_WORDS];
   logic [31:0]        mem_rdata_q;

   // Response pipeline: stage 0 is loaded at the accepting edge, stage
   // LATENCY-1 drives the bus.
   logic [LATENCY-1:0] valid_q, valid_d;
   logic [LATENCY-1:0] err_q, err_d;
   logic [31:0]        rdata_q [LATENCY];
   logic [31:0]        rdata_d [LATENCY];

   // Stage 0 of an in-range read takes its data from the registered SRAM
   // output rather than from rdata_q[0]; this flag selects between them.
   logic               mem_sel_q, mem_sel_d;

   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // ---------------------------------------------------------------------------
   // Request decode and grant
   // ---------------------------------------------------------------------------
   logic [IDX_W-1:0]   idx;
   logic               in_range;
   logic               gnt;
   logic               accept;
   logic               wr_en;
   logic               rd_en;
   logic               retire;
   logic [31:0]        stage0_rdata;
   logic [31:0]        out_rdata;

   always_comb begin
      idx      = obi_req_i.addr[IDX_W+1:2];
      // Any address bit above the word-index field, or an index past the
      // last word, makes the access out of range. addr[1:0] is ignored.
      in_range = ((obi_req_i.addr >> (IDX_W + 2)) == 32'd0) &&
                 ({1'b0, idx} < MEM_WORDS_L);
      // Grant looks only at the registered counter, so a response leaving in
      // this cycle cannot open a slot combinationally. rst_ni keeps the grant
      // low while reset is held.
      gnt      = rst_ni & obi_req_i.req & ~stall_i & (cnt_q < MAX_OUT_L);
      accept   = gnt;
      wr_en    = accept &  obi_req_i.we & in_range;
      rd_en    = accept & ~obi_req_i.we & in_range;
   end

   // ---------------------------------------------------------------------------
   // SRAM: byte-enabled write, registered read. Only one access is accepted
   // per edge, so a read always sees writes from earlier edges.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (obi_req_i.be[b]) begin
               mem_q[idx][8*b +: 8] <= obi_req_i.wdata[8*b +: 8];
            end
         end
      end
      if (rd_en) begin
         mem_rdata_q <= mem_q[idx];
      end
   end

   // ---------------------------------------------------------------------------
   // Response pipeline next state
   // ---------------------------------------------------------------------------
   always_comb begin
      stage0_rdata = mem_sel_q ? mem_rdata_q : rdata_q[0];

      valid_d[0]   = accept;
      err_d[0]     = accept & ~in_range;
      // Writes answer with zero data; out-of-range reads with ERR_DATA; in-range
      // reads are filled in from the SRAM register through mem_sel.
      rdata_d[0]   = (accept & ~obi_req_i.we & ~in_range) ? ERR_DATA : 32'd0;
      mem_sel_d    = rd_en;

      for (int i = 1; i < LATENCY; i++) begin
         valid_d[i] = valid_q[i-1];
         err_d[i]   = err_q[i-1];
         rdata_d[i] = (i == 1) ? stage0_rdata : rdata_q[i-1];
      end
   end

   // A slot is released on the edge that launches its rvalid, i.e. when the
   // transaction moves into the output stage. With LATENCY=1 that is the
   // accepting edge itself, so the count never moves.
   if (LATENCY == 1) begin : g_lat1
      assign retire    = accept;
      assign out_rdata = stage0_rdata;
   end else begin : g_latn
      assign retire    = valid_q[LATENCY-2];
      assign out_rdata = rdata_q[LATENCY-1];
   end

   always_comb begin
      case ({accept, retire})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers: reset drops every in-flight response and clears the counter.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q   <= '0;
         err_q     <= '0;
         mem_sel_q <= 1'b0;
         cnt_q     <= '0;
         for (int i = 0; i < LATENCY; i++) begin
            rdata_q[i] <= 32'd0;
         end
      end else begin
         valid_q   <= valid_d;
         err_q     <= err_d;
         mem_sel_q <= mem_sel_d;
         cnt_q     <= cnt_d;
         rdata_q   <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs: data and error are forced to zero outside the rvalid cycle.
   // ---------------------------------------------------------------------------
   always_comb begin
      obi_resp_o        = '0;
      obi_resp_o.gnt    = gnt;
      obi_resp_o.rvalid = valid_q[LATENCY-1];
      obi_resp_o.rdata  = valid_q[LATENCY-1] ? out_rdata : 32'd0;
      err_o             = valid_q[LATENCY-1] & err_q[LATENCY-1];
   end

endmodule
